// File: rtl/at25010_responder.sv
// AT25010-style SPI-slave EEPROM emulator: 128x8 array, status register, WEN latch, timed write cycle.
// Optional macro BLOCK_PROTECT_EN makes BP1:BP0 discard page writes into the protected region.
module at25010_responder #(
  parameter int MEM_DEPTH    = 128,
  parameter int PAGE_SIZE    = 8,
  parameter int WRITE_CYCLES = 500,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       write_busy,
  output logic [7:0] status_q
);

  localparam int AW  = $clog2(MEM_DEPTH);
  localparam int CW  = $clog2(PAGE_SIZE);
  localparam int WCW = $clog2(WRITE_CYCLES + 1);

  localparam logic [2:0] OP_WRSR  = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_READ  = 3'b011;
  localparam logic [2:0] OP_WRDI  = 3'b100;
  localparam logic [2:0] OP_RDSR  = 3'b101;
  localparam logic [2:0] OP_WREN  = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_RD_DATA, ST_WR_DATA, ST_RD_STATUS, ST_WR_STATUS, ST_IGNORE
  } state_t;

  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
  logic                   r_cs_d, r_sclk_d;
  logic [2:0]             r_bit_cnt;
  logic [1:0]             r_byte_cnt;
  logic [6:0]             r_shift;
  logic [2:0]             r_op;
  logic                   r_op_ok;
  logic [AW-1:0]          r_addr;
  logic [7:0]             r_tx;
  logic                   r_miso, r_fresh;
  logic [1:0]             r_wrsr_bp;
  logic [7:0]             r_pbuf [PAGE_SIZE];
  logic [PAGE_SIZE-1:0]   r_pvalid;
  logic [7:0]             r_mem [MEM_DEPTH];
  logic                   r_nrdy, r_wen;
  logic [1:0]             r_bp;
  logic [WCW-1:0]         r_wcnt;

  logic          w_cs, w_sclk, w_mosi;
  logic          w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic          w_byte_done;
  logic [7:0]    w_byte, w_status, w_mem_byte, w_mem_next;
  logic [2:0]    w_op;
  logic          w_op_allowed;
  logic [AW-1:0] w_addr_inc;
  logic [AW-CW-1:0] w_page;
  logic          w_do_wren, w_do_wrdi, w_do_wrsr, w_do_write, w_commit, w_protected;
  logic          w_miso_oe;

  // Synchronizers and edge detectors; CS idles high so no spurious fall leaves reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_d      <= w_cs;
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;

  assign w_byte       = {r_shift, w_mosi};
  assign w_byte_done  = ~w_cs & w_sclk_rise & (r_bit_cnt == 3'd7);
  assign w_op         = w_byte[2:0];
  assign w_op_allowed = (w_byte[7:4] == 4'h0) && (w_op != 3'b000) && (w_op != 3'b111) &&
                        (!r_nrdy || (w_op == OP_RDSR));
  assign w_status     = {4'h0, r_bp, r_wen, r_nrdy};
  assign w_addr_inc   = r_addr + AW'(1);
  assign w_mem_byte   = r_mem[w_byte[AW-1:0]];
  assign w_mem_next   = r_mem[w_addr_inc];
  assign w_page       = r_addr[AW-1:CW];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state; CS high always wins over any SCLK activity
  always_comb begin
    w_next = r_state;
    if (w_cs) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall) w_next = ST_CMD;
        ST_CMD: if (w_byte_done) begin
          if (!w_op_allowed)                          w_next = ST_IGNORE;
          else if (w_op == OP_RDSR)                   w_next = ST_RD_STATUS;
          else if (w_op == OP_WRSR && r_wen)          w_next = ST_WR_STATUS;
          else if (w_op == OP_READ || w_op == OP_WRITE) w_next = ST_ADDR;
          else                                        w_next = ST_IGNORE;
        end
        ST_ADDR:      if (w_byte_done) w_next = (r_op == OP_READ) ? ST_RD_DATA : ST_WR_DATA;
        ST_WR_STATUS: if (w_byte_done) w_next = ST_IGNORE;
        default:      w_next = r_state;
      endcase
    end
  end

  // FSM: outputs and CS-rise actions (exact bit counts qualify each command)
  always_comb begin
    w_miso_oe  = (r_state == ST_RD_DATA) || (r_state == ST_RD_STATUS);
    w_do_wren  = w_cs_rise && r_op_ok && (r_op == OP_WREN) && (r_byte_cnt == 2'd1) && (r_bit_cnt == 3'd0);
    w_do_wrdi  = w_cs_rise && r_op_ok && (r_op == OP_WRDI) && (r_byte_cnt == 2'd1) && (r_bit_cnt == 3'd0);
    w_do_wrsr  = w_cs_rise && r_op_ok && (r_op == OP_WRSR) && r_wen &&
                 (r_byte_cnt == 2'd2) && (r_bit_cnt == 3'd0);
    w_do_write = w_cs_rise && r_op_ok && (r_op == OP_WRITE) && r_wen &&
                 (r_byte_cnt == 2'd3) && (r_bit_cnt == 3'd0);
    w_commit   = w_do_write && !w_protected;
  end

`ifdef BLOCK_PROTECT_EN
  always_comb begin
    case (r_bp)
      2'b01:   w_protected = (r_addr >= AW'(MEM_DEPTH * 3 / 4));
      2'b10:   w_protected = (r_addr >= AW'(MEM_DEPTH / 2));
      2'b11:   w_protected = 1'b1;
      default: w_protected = 1'b0;
    endcase
  end
`else
  assign w_protected = 1'b0;
`endif

  // Bit/byte counting, command capture, page buffering and MISO shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_op       <= '0;
      r_op_ok    <= 1'b0;
      r_addr     <= '0;
      r_tx       <= '0;
      r_miso     <= 1'b0;
      r_fresh    <= 1'b0;
      r_wrsr_bp  <= '0;
      r_pvalid   <= '0;
      for (int i = 0; i < PAGE_SIZE; i++) r_pbuf[i] <= '0;
    end else if (w_cs) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_fresh    <= 1'b0;
    end else if (w_sclk_rise) begin
      r_shift   <= w_byte[6:0];
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (r_bit_cnt == 3'd7 && r_byte_cnt != 2'd3) r_byte_cnt <= r_byte_cnt + 2'd1;
      if (r_bit_cnt == 3'd7) begin
        case (r_state)
          ST_CMD: begin
            r_op    <= w_op;
            r_op_ok <= w_op_allowed;
            if (w_op_allowed && w_op == OP_RDSR) begin
              r_tx    <= w_status;
              r_miso  <= w_status[7];
              r_fresh <= 1'b1;
            end
          end
          ST_ADDR: begin
            r_addr <= w_byte[AW-1:0];
            if (r_op == OP_READ) begin
              r_tx    <= w_mem_byte;
              r_miso  <= w_mem_byte[7];
              r_fresh <= 1'b1;
            end else begin
              r_pvalid <= '0;
            end
          end
          ST_WR_DATA: begin
            r_pbuf[r_addr[CW-1:0]]   <= w_byte;
            r_pvalid[r_addr[CW-1:0]] <= 1'b1;
            r_addr[CW-1:0]           <= r_addr[CW-1:0] + CW'(1);
          end
          ST_WR_STATUS: r_wrsr_bp <= w_byte[3:2];
          default: ;
        endcase
      end
    end else if (w_sclk_fall && w_miso_oe) begin
      // The fall right after a rise-time load keeps bit 7 on the line
      if (r_fresh) begin
        r_fresh <= 1'b0;
      end else if (r_bit_cnt == 3'd0) begin
        if (r_state == ST_RD_DATA) begin
          r_addr <= w_addr_inc;
          r_tx   <= w_mem_next;
          r_miso <= w_mem_next[7];
        end else begin
          r_tx   <= w_status;
          r_miso <= w_status[7];
        end
      end else begin
        r_tx   <= {r_tx[6:0], 1'b0};
        r_miso <= r_tx[6];
      end
    end
  end

  // Status register and write-cycle timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nrdy <= 1'b0;
      r_wen  <= 1'b0;
      r_bp   <= '0;
      r_wcnt <= '0;
    end else begin
      if (r_nrdy) begin
        if (r_wcnt == WCW'(1)) r_nrdy <= 1'b0;
        r_wcnt <= r_wcnt - WCW'(1);
      end
      if (w_do_wren) r_wen <= 1'b1;
      if (w_do_wrdi) r_wen <= 1'b0;
      if (w_do_wrsr) begin
        r_bp   <= r_wrsr_bp;
        r_wen  <= 1'b0;
        r_nrdy <= 1'b1;
        r_wcnt <= WCW'(WRITE_CYCLES);
      end
      if (w_do_write) r_wen <= 1'b0;
      if (w_commit) begin
        r_nrdy <= 1'b1;
        r_wcnt <= WCW'(WRITE_CYCLES);
      end
    end
  end

  // Storage array; only columns touched by the page write are committed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 8'hFF;
    end else if (w_commit) begin
      for (int c = 0; c < PAGE_SIZE; c++)
        if (r_pvalid[c]) r_mem[{w_page, CW'(c)}] <= r_pbuf[c];
    end
  end

  assign spi_miso    = w_miso_oe ? r_miso : 1'b0;
  assign spi_miso_oe = w_miso_oe;
  assign write_busy  = r_nrdy;
  assign status_q    = w_status;

endmodule

// File: tb/tb_at25010_responder.sv
// Directed bench for at25010_responder: SPI mode 0 master at clk/8, checks via immediate assertions.
module tb_at25010_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, write_busy;
  logic [7:0] status_q;

  int tests = 0;
  int fails = 0;

  at25010_responder dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .write_busy(write_busy), .status_q(status_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low;
    clks(1);
    spi_cs_n = 1'b0;
    clks(4);
  endtask

  task automatic cs_high;
    clks(4);
    spi_cs_n = 1'b1;
    clks(6);
  endtask

  // Raise CS and count clk cycles with write_busy high (bounded)
  task automatic cs_high_measure(output int n);
    clks(4);
    spi_cs_n = 1'b1;
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (write_busy) n++;
      else if (n > 0 || k > 20) break;
    end
    clks(2);
  endtask

  task automatic wait_not_busy(output int n);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!write_busy) break;
      n++;
    end
    clks(2);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      clks(4);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      clks(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cmd1(input logic [7:0] op);
    logic [7:0] d;
    cs_low;
    xfer(op, d);
    cs_high;
  endtask

  task automatic read3(input logic [7:0] a, output logic [7:0] b0, output logic [7:0] b1,
                       output logic [7:0] b2);
    logic [7:0] d;
    cs_low;
    xfer(8'h03, d);
    xfer(a, d);
    xfer(8'h00, b0);
    xfer(8'h00, b1);
    xfer(8'h00, b2);
    cs_high;
  endtask

  task automatic rdsr(output logic [7:0] s);
    logic [7:0] d;
    cs_low;
    xfer(8'h05, d);
    xfer(8'h00, s);
    cs_high;
  endtask

  // Leaves CS low; caller ends the frame
  task automatic write_open(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input int n);
    logic [7:0] d;
    cs_low;
    xfer(8'h02, d);
    xfer(a, d);
    if (n > 0) xfer(d0, d);
    if (n > 1) xfer(d1, d);
    if (n > 2) xfer(d2, d);
  endtask

  logic [7:0] b0, b1, b2, s, d;
  int         n;

  initial begin
    clks(5);
    rst_n = 1'b1;
    clks(4);
    chk("reset_status", status_q, 8'h00);
    chk("reset_busy", write_busy, 1'b0);
    chk("reset_oe", spi_miso_oe, 1'b0);
    chk("reset_miso", spi_miso, 1'b0);

    // RDSR repeats the status every byte
    cs_low;
    xfer(8'h05, d);
    xfer(8'h00, b0);
    xfer(8'h00, b1);
    chk("rdsr_oe", spi_miso_oe, 1'b1);
    cs_high;
    chk("rdsr_b0", b0, 8'h00);
    chk("rdsr_b1", b1, 8'h00);
    chk("cs_high_oe", spi_miso_oe, 1'b0);

    read3(8'h10, b0, b1, b2);
    chk("read_erased", b0, 8'hFF);

    cmd1(8'h06);
    chk("wren_status", status_q, 8'h02);
    write_open(8'h05, 8'hA5, 8'h3C, 8'h00, 2);
    cs_high_measure(n);
    chk("write_busy_cycles", n, 500);
    chk("post_write_status", status_q, 8'h00);
    read3(8'h05, b0, b1, b2);
    chk("read05_b0", b0, 8'hA5);
    chk("read05_b1", b1, 8'h3C);
    chk("read05_b2", b2, 8'hFF);

    // Write without WEN must be dropped
    write_open(8'h20, 8'h11, 8'h00, 8'h00, 1);
    cs_high_measure(n);
    chk("nowen_busy_cycles", n, 0);
    read3(8'h20, b0, b1, b2);
    chk("nowen_read20", b0, 8'hFF);

    // Page wrap write; probe status and READ while busy
    cmd1(8'h06);
    write_open(8'h06, 8'h01, 8'h02, 8'h03, 3);
    cs_high;
    chk("busy_after_commit", write_busy, 1'b1);
    chk("busy_status", status_q, 8'h01);
    rdsr(s);
    chk("rdsr_while_busy", s, 8'h01);
    cs_low;
    xfer(8'h03, d);
    xfer(8'h06, d);
    chk("read_ignored_busy_oe", spi_miso_oe, 1'b0);
    cs_high;
    wait_not_busy(n);
    chk("busy_cleared", write_busy, 1'b0);
    read3(8'h06, b0, b1, b2);
    chk("wrap_06", b0, 8'h01);
    chk("wrap_07", b1, 8'h02);
    chk("wrap_08", b2, 8'hFF);
    read3(8'h00, b0, b1, b2);
    chk("wrap_00", b0, 8'h03);
    read3(8'h04, b0, b1, b2);
    chk("keep_04", b0, 8'hFF);
    chk("keep_05", b1, 8'hA5);
    chk("keep_06", b2, 8'h01);

    // Address rollover on READ
    cmd1(8'h06);
    write_open(8'h7E, 8'h7E, 8'h7F, 8'h00, 2);
    cs_high_measure(n);
    chk("write7e_busy_cycles", n, 500);
    read3(8'h7E, b0, b1, b2);
    chk("roll_7e", b0, 8'h7E);
    chk("roll_7f", b1, 8'h7F);
    chk("roll_00", b2, 8'h03);

    cmd1(8'h06);
    cmd1(8'h04);
    chk("wrdi_status", status_q, 8'h00);

    // WRSR sets BP1:BP0 only
    cmd1(8'h06);
    cs_low;
    xfer(8'h01, d);
    xfer(8'hFF, d);
    cs_high_measure(n);
    chk("wrsr_busy_cycles", n, 500);
    chk("wrsr_status", status_q, 8'h0C);

    cmd1(8'h06);
    write_open(8'h00, 8'h55, 8'h00, 8'h00, 1);
    cs_high_measure(n);
`ifdef BLOCK_PROTECT_EN
    chk("protected_busy_cycles", n, 0);
    read3(8'h00, b0, b1, b2);
    chk("protected_00", b0, 8'h03);
`else
    chk("unprotected_busy_cycles", n, 500);
    read3(8'h00, b0, b1, b2);
    chk("unprotected_00", b0, 8'h55);
`endif
    rdsr(s);
    chk("final_rdsr", s, 8'h0C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
